// File: rtl/background_fill_ctrl.sv
// background_fill_ctrl
//
// Write-port controller for the background frame memory. The memory is
// WIDTH x HEIGHT pixels stored column-major (address = y + HEIGHT*x).
// The controller turns rectangle-fill commands into one write per pixel.
// It also takes single-pixel writes from a second requester, which always
// have priority over the fill.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : fill command handshake
//   cmd_x0..cmd_y1        : inclusive rectangle bounds
//   cmd_color             : fill colour
//   px_valid/px_ready     : single-pixel write handshake
//   px_x, px_y, px_color  : single-pixel write
//   busy                  : a fill is in progress
//   done                  : one-cycle pulse on fill completion or rejection
//   err                   : one-cycle pulse on a rejected command
//   ram_waddr/ram_din/ram_we : registered memory write port
module background_fill_ctrl #(
  parameter  int NUMBER_COLORS = 10,
  parameter  int WIDTH         = 320,
  parameter  int HEIGHT        = 240,
  localparam int CW            = $clog2(NUMBER_COLORS) + 1,
  localparam int AW            = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [8:0]    cmd_x0,
  input  logic [8:0]    cmd_x1,
  input  logic [7:0]    cmd_y0,
  input  logic [7:0]    cmd_y1,
  input  logic [CW-1:0] cmd_color,
  input  logic          px_valid,
  output logic          px_ready,
  input  logic [8:0]    px_x,
  input  logic [7:0]    px_y,
  input  logic [CW-1:0] px_color,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_waddr,
  output logic [CW-1:0] ram_din,
  output logic          ram_we
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t        state, state_next;

  logic [8:0]    x0_q, x1_q, x0_next, x1_next;
  logic [7:0]    y0_q, y1_q, y0_next, y1_next;
  logic [CW-1:0] color_q, color_next;
  logic [8:0]    cur_x, cur_x_next;
  logic [7:0]    cur_y, cur_y_next;

  logic          we_next;
  logic [AW-1:0] waddr_next;
  logic [CW-1:0] din_next;
  logic          done_next;
  logic          err_next;

  logic          px_accept;
  logic          px_in_range;
  logic          cmd_bad;
  logic          last_step;

  // Column-major address, computed at full address width so the top
  // corner (WIDTH*HEIGHT-1) is reachable without truncation.
  function automatic logic [AW-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return AW'(y) + AW'(HEIGHT) * AW'(x);
  endfunction

  assign cmd_ready   = (state == IDLE) && !reset;
  assign px_ready    = !reset;
  assign busy        = (state == FILL);
  assign px_accept   = px_valid && px_ready;
  assign px_in_range = (32'(px_x) < 32'(WIDTH)) && (32'(px_y) < 32'(HEIGHT));
  assign cmd_bad     = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) ||
                       (32'(cmd_x1) >= 32'(WIDTH)) || (32'(cmd_y1) >= 32'(HEIGHT));
  assign last_step   = (cur_x == x1_q) && (cur_y == y1_q);

  // Next-state and next-output logic. A pixel write goes to the memory port
  // first. An accepted pixel, even an out-of-range one that is dropped,
  // stalls the fill for that cycle so the two never collide. The fill walks
  // y fastest so consecutive writes hit consecutive addresses.
  always_comb begin
    state_next = state;
    x0_next    = x0_q;
    x1_next    = x1_q;
    y0_next    = y0_q;
    y1_next    = y1_q;
    color_next = color_q;
    cur_x_next = cur_x;
    cur_y_next = cur_y;
    we_next    = 1'b0;
    waddr_next = ram_waddr;
    din_next   = ram_din;
    done_next  = 1'b0;
    err_next   = 1'b0;

    if (px_accept && px_in_range) begin
      we_next    = 1'b1;
      waddr_next = pix_addr(px_x, px_y);
      din_next   = px_color;
    end

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_bad) begin
            err_next  = 1'b1;
            done_next = 1'b1;
          end else begin
            x0_next    = cmd_x0;
            x1_next    = cmd_x1;
            y0_next    = cmd_y0;
            y1_next    = cmd_y1;
            color_next = cmd_color;
            cur_x_next = cmd_x0;
            cur_y_next = cmd_y0;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (!px_accept) begin
          we_next    = 1'b1;
          waddr_next = pix_addr(cur_x, cur_y);
          din_next   = color_q;
          if (last_step) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (cur_y == y1_q) begin
            cur_y_next = y0_q;
            cur_x_next = cur_x + 9'd1;
          end else begin
            cur_y_next = cur_y + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered memory port. Reset drops any fill in flight
  // and silences the write port straight away.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_din   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      x0_q      <= x0_next;
      x1_q      <= x1_next;
      y0_q      <= y0_next;
      y1_q      <= y1_next;
      color_q   <= color_next;
      cur_x     <= cur_x_next;
      cur_y     <= cur_y_next;
      ram_we    <= we_next;
      ram_waddr <= waddr_next;
      ram_din   <= din_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_background_fill_ctrl.sv
// tb_background_fill_ctrl
//
// Drives directed and random fill/pixel traffic into background_fill_ctrl.
// A reference model turns each cycle's inputs into the expected output for
// the following cycle and pushes it into a queue. A monitor pops and
// compares those expectations against the registered DUT outputs.
module tb_background_fill_ctrl;

  localparam int CW = 5;
  localparam int AW = 17;
  localparam int W  = 320;
  localparam int H  = 240;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [8:0]    cmd_x0, cmd_x1;
  logic [7:0]    cmd_y0, cmd_y1;
  logic [CW-1:0] cmd_color;
  logic          px_valid;
  logic          px_ready;
  logic [8:0]    px_x;
  logic [7:0]    px_y;
  logic [CW-1:0] px_color;
  logic          busy, done, err;
  logic [AW-1:0] ram_waddr;
  logic [CW-1:0] ram_din;
  logic          ram_we;

  always #5 clk = ~clk;

  background_fill_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_color  (px_color),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .ram_we    (ram_we)
  );

  typedef struct packed {
    logic          rst;
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] din;
    logic          done;
    logic          err;
    logic          busy;
  } exp_t;

  exp_t          exp_q[$];
  int            fill_q[$];
  logic [CW-1:0] fill_color;
  bit            fill_active = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: one call per clock cycle, using the inputs about to be
  // sampled. An accepted fill becomes a list of all its addresses in
  // column-major order; each cycle without a pixel takes the next one.
  task automatic modelStep();
    exp_t e;
    bit   bad;
    e = '0;
    if (reset) begin
      fill_q.delete();
      fill_active = 1'b0;
      e.rst = 1'b1;
    end else begin
      if (px_valid && int'(px_x) < W && int'(px_y) < H) begin
        e.we   = 1'b1;
        e.addr = AW'(int'(px_y) + H * int'(px_x));
        e.din  = px_color;
      end
      if (fill_active) begin
        if (!px_valid) begin
          e.we   = 1'b1;
          e.addr = AW'(fill_q.pop_front());
          e.din  = fill_color;
          if (fill_q.size() == 0) begin
            e.done      = 1'b1;
            fill_active = 1'b0;
          end
        end
      end else if (cmd_valid) begin
        bad = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) || (int'(cmd_x1) >= W) || (int'(cmd_y1) >= H);
        if (bad) begin
          e.err  = 1'b1;
          e.done = 1'b1;
        end else begin
          for (int x = int'(cmd_x0); x <= int'(cmd_x1); x++)
            for (int y = int'(cmd_y0); y <= int'(cmd_y1); y++)
              fill_q.push_back(y + H * x);
          fill_color  = cmd_color;
          fill_active = 1'b1;
        end
      end
    end
    e.busy = fill_active;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus. Inputs change on the falling edge; the
  // ready outputs are checked once they settle, then the model advances.
  task automatic applyStimulus(input bit rst, input bit cv,
                               input logic [8:0] x0, input logic [7:0] y0,
                               input logic [8:0] x1, input logic [7:0] y1,
                               input logic [CW-1:0] cc,
                               input bit pv, input logic [8:0] pxx,
                               input logic [7:0] pxy, input logic [CW-1:0] pc);
    @(negedge clk);
    reset     = rst;
    cmd_valid = cv;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = cc;
    px_valid  = pv;
    px_x      = pxx;
    px_y      = pxy;
    px_color  = pc;
    #1;
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(!rst && !fill_active));
    checkOutput("px_ready", 32'(px_ready), 32'(!rst));
    modelStep();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sendFill(input logic [8:0] x0, input logic [7:0] y0,
                          input logic [8:0] x1, input logic [7:0] y1,
                          input logic [CW-1:0] c);
    applyStimulus(0, 1, x0, y0, x1, y1, c, 0, 0, 0, 0);
  endtask

  task automatic sendPixel(input logic [8:0] x, input logic [7:0] y, input logic [CW-1:0] c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, x, y, c);
  endtask

  // Drain any fill in progress, bounded by a cycle budget.
  task automatic waitIdle();
    int budget = 2000;
    while (fill_active && budget > 0) begin
      idleCycles(1);
      budget--;
    end
    if (fill_active)
      checkOutput("drain_timeout", 32'(1), 32'(0));
  endtask

  // Monitor: every cycle with a pending expectation is compared field by field.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("ram_we", 32'(ram_we), 32'(e.we));
      if (e.we) begin
        checkOutput("ram_waddr", 32'(ram_waddr), 32'(e.addr));
        checkOutput("ram_din", 32'(ram_din), 32'(e.din));
      end
      if (e.rst) begin
        checkOutput("reset_waddr", 32'(ram_waddr), 32'(0));
        checkOutput("reset_din", 32'(ram_din), 32'(0));
      end
      checkOutput("done", 32'(done), 32'(e.done));
      checkOutput("err", 32'(err), 32'(e.err));
      checkOutput("busy", 32'(busy), 32'(e.busy));
    end
  end

  initial begin
    logic [8:0]    rx0, rx1, rpx;
    logic [7:0]    ry0, ry1, rpy;
    logic [CW-1:0] rc, rpc;
    bit            rrst, rcv, rpv;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    px_valid  = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
    px_x = '0; px_y = '0; px_color = '0;

    resetCycles(3);
    idleCycles(2);

    $display("[TB] basic fill");
    sendFill(0, 0, 1, 2, 5);
    waitIdle();
    idleCycles(2);

    $display("[TB] corner pixel");
    sendPixel(319, 239, 3);
    idleCycles(2);

    $display("[TB] pixel priority during fill");
    sendFill(10, 0, 10, 3, 2);
    idleCycles(1);
    sendPixel(5, 5, 7);
    waitIdle();
    idleCycles(2);

    $display("[TB] rejected commands");
    sendFill(5, 0, 4, 0, 1);
    idleCycles(2);
    sendFill(0, 0, 0, 240, 1);
    idleCycles(2);

    $display("[TB] single-pixel fill and back-to-back command");
    sendFill(7, 9, 7, 9, 4);
    sendFill(1, 1, 1, 1, 6);
    waitIdle();
    sendFill(2, 3, 2, 3, 9);
    idleCycles(3);

    $display("[TB] simultaneous command and pixel in idle");
    applyStimulus(0, 1, 300, 200, 301, 201, 12, 1, 0, 0, 31);
    waitIdle();
    idleCycles(2);

    $display("[TB] out-of-range pixel");
    sendPixel(320, 0, 1);
    sendPixel(0, 240, 1);
    idleCycles(2);

    $display("[TB] reset mid-fill");
    sendFill(0, 0, 319, 239, 8);
    idleCycles(101);
    resetCycles(2);
    idleCycles(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      rrst = ($urandom_range(0, 299) == 0);
      rcv  = ($urandom_range(0, 5) == 0);
      rpv  = ($urandom_range(0, 3) == 0);
      rx0  = 9'($urandom_range(0, 319));
      ry0  = 8'($urandom_range(0, 239));
      rx1  = rx0 + 9'($urandom_range(0, 3));
      ry1  = ry0 + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0 && rx0 > 0) rx1 = rx0 - 9'd1;
      if ($urandom_range(0, 9) == 0 && ry0 > 0) ry1 = ry0 - 8'd1;
      rc   = CW'($urandom_range(0, 31));
      rpx  = 9'($urandom_range(0, 330));
      rpy  = 8'($urandom_range(0, 250));
      rpc  = CW'($urandom_range(0, 31));
      applyStimulus(rrst, rcv, rx0, ry0, rx1, ry1, rc, rpv, rpx, rpy, rpc);
    end
    waitIdle();
    idleCycles(3);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/background_fill_ctrl.md
# background_fill_ctrl

Write-port controller for the background frame memory (320×240, column-major, address = y + 240·x). Sequences rectangle-fill commands into per-pixel writes and arbitrates them against single-pixel writes from a second requester. Drives the memory's `waddr`/`din`/`we` port directly; the memory's read side is untouched.

## Interface

Parameters:
- `NUMBER_COLORS`, default 10: palette size. Colour width is CW = $clog2(NUMBER_COLORS)+1.
- `WIDTH`, default 320: columns (x range 0..WIDTH-1).
- `HEIGHT`, default 240: rows (y range 0..HEIGHT-1).

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: fill command offered.
- `cmd_ready` out 1: fill command accepted when both are high.
- `cmd_x0`, `cmd_x1` in 9: inclusive column bounds.
- `cmd_y0`, `cmd_y1` in 8: inclusive row bounds.
- `cmd_color` in CW: fill colour.
- `px_valid` in 1: single-pixel write offered.
- `px_ready` out 1: pixel accepted when both are high.
- `px_x` in 9, `px_y` in 8, `px_color` in CW: pixel write.
- `busy` out 1: fill in progress.
- `done` out 1: one-cycle pulse at fill completion or rejection.
- `err` out 1: one-cycle pulse on a rejected command.
- `ram_waddr` out $clog2(WIDTH*HEIGHT): memory write address.
- `ram_din` out CW: memory write data.
- `ram_we` out 1: memory write enable.

## Operation

- FSM states: IDLE and FILL.
- `cmd_ready` = (state == IDLE) and not `reset`. `px_ready` = not `reset`.
- Command acceptance in IDLE:
  - A command is rejected if x0 > x1, y0 > y1, x1 ≥ WIDTH or y1 ≥ HEIGHT.
  - A rejected command is consumed. The next cycle pulses `err` and `done`, issues no writes, and the FSM stays in IDLE.
  - A valid command latches its bounds and colour, sets cur_x = x0 and cur_y = y0, and moves to FILL.
- Traversal in FILL:
  - y is the inner loop, matching the column-major layout. Sequence: (x0,y0), (x0,y0+1) … (x0,y1), (x0+1,y0) … (x1,y1).
  - Total writes = (x1−x0+1)·(y1−y0+1).
- Arbitration:
  - A pixel write has fixed priority.
  - In any FILL cycle where a pixel is accepted, the fill step stalls: cur_x and cur_y hold, and the fill issues no write.
  - Each accepted request produces exactly one write.
- Out-of-range pixel (px_x ≥ WIDTH or px_y ≥ HEIGHT): accepted and dropped. No write and no `err`.
- Address arithmetic: waddr = y + HEIGHT·x, computed at full address width with no truncation. The maximum address is WIDTH·HEIGHT−1 = 76799.
- After the last fill write is issued, the FSM returns to IDLE.
- `busy` = (state == FILL).
- A new command is not accepted in the cycle FILL exits. `cmd_ready` rises the following cycle.

## Timing

- Reset values:
  - `ram_we`, `ram_waddr`, `ram_din`, `done`, `err` and `busy` are all 0.
  - State is IDLE.
  - `cmd_ready` and `px_ready` are 0 while `reset` is high.
- Reset mid-fill aborts the fill immediately. No further writes occur, and `done` does not pulse for the aborted command.
- `ram_waddr`, `ram_din` and `ram_we` are registered, with 1-cycle latency:
  - A pixel accepted in cycle N, or a fill step taken in cycle N, appears on the memory port in cycle N+1.
- Fill command accepted in cycle N:
  - FSM is in FILL from N+1.
  - First write appears at N+2, and further writes follow on consecutive cycles absent stalls.
  - A 1×1 fill writes at N+2.
- `done` is asserted in the same cycle `ram_we` carries the final fill write.
- The FSM is back in IDLE in that same cycle. `cmd_ready` is therefore high in that cycle, and a new command can be accepted then.
- A rejected command accepted in cycle N pulses `err` and `done` in cycle N+1.
- A simultaneous `cmd_valid` and `px_valid` in IDLE are both accepted in the same cycle. The pixel write issues at N+1 and the fill starts normally.

## Test plan

1. **Basic fill.** Fill (x0,y0,x1,y1) = (0,0,1,2) with colour 5, accepted at cycle N.
   - Required: writes at cycles N+2..N+7 to addresses 0, 1, 2, 240, 241, 242, all with din 5.
   - `done` high at N+7 only. `busy` high for N+1..N+6.
2. **Corner pixel.** Pixel (319,239) with colour 3 accepted at cycle N.
   - Required: `ram_we` at N+1 with waddr 76799 and din 3. Exactly one write.
3. **Pixel priority during fill.** Fill (10,0,10,3) with colour 2, and a pixel (5,5) with colour 7 accepted in the 2nd FILL cycle.
   - Required write order: 2400, 5+1200=1205 (colour 7), 2401, 2402, 2403.
   - `done` coincides with the write to 2403.
4. **Rejected command.** Command with x0 = 5, x1 = 4.
   - Required: `err` and `done` high one cycle after acceptance. No `ram_we`. `busy` stays 0.
   - Repeat with y1 = 240: same response.
5. **Reset mid-fill.** Fill (0,0,319,239), with `reset` asserted after 100 writes.
   - Required: `ram_we` = 0 from the cycle after `reset` is sampled. No `done`. `cmd_ready` = 1 in the first cycle after `reset` deasserts.
6. **Out-of-range pixel.** Pixel (320,0).
   - Required: `px_ready` = 1, no write, no `err`.
